// File: rtl/mem_lsu.sv
//==========================================================================
// mem_lsu : memory-access stage, byte/half/word loads and stores over a
//           req/ack bus. Optional macro: MEM_ALIGN_EXC_EN. Revision 1.0
//==========================================================================
`default_nettype none

module mem_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wd_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [7:0]  ex_aluop_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_reg2_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        mem_wreg_o,
  output logic [4:0]  mem_wd_o,
  output logic [31:0] mem_wdata_o,
  output logic        stallreq_o
`ifdef MEM_ALIGN_EXC_EN
  ,
  output logic        mem_misalign_o
`endif
);

  localparam logic [7:0] C_EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] C_EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] C_EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] C_EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] C_EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] C_EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] C_EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] C_EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] C_SZ_BYTE = 2'd0;
  localparam logic [1:0] C_SZ_HALF = 2'd1;
  localparam logic [1:0] C_SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] rdata_q;

  logic        w_is_mem, w_is_store, w_is_load, w_signed;
  logic [1:0]  w_size, w_off;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d, addr_d, w_load_ext;
  logic        w_misalign, w_issue, w_idle_view;

  // Operation decode
  always_comb begin
    w_is_mem   = 1'b1;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = C_SZ_WORD;
    case (ex_aluop_i)
      C_EXE_LB_OP:  begin w_size = C_SZ_BYTE; w_signed = 1'b1; end
      C_EXE_LBU_OP: w_size = C_SZ_BYTE;
      C_EXE_LH_OP:  begin w_size = C_SZ_HALF; w_signed = 1'b1; end
      C_EXE_LHU_OP: w_size = C_SZ_HALF;
      C_EXE_LW_OP:  w_size = C_SZ_WORD;
      C_EXE_SB_OP:  begin w_size = C_SZ_BYTE; w_is_store = 1'b1; end
      C_EXE_SH_OP:  begin w_size = C_SZ_HALF; w_is_store = 1'b1; end
      C_EXE_SW_OP:  begin w_size = C_SZ_WORD; w_is_store = 1'b1; end
      default:      w_is_mem = 1'b0;
    endcase
    w_is_load = w_is_mem & ~w_is_store;
  end

  // Lane selection; low address bits beyond the access size are dropped
  always_comb begin
    w_off   = 2'b00;
    sel_d   = 4'b1111;
    wdata_d = ex_reg2_i;
    case (w_size)
      C_SZ_BYTE: begin
        w_off   = ex_mem_addr_i[1:0];
        sel_d   = 4'b1000 >> w_off;
        wdata_d = {4{ex_reg2_i[7:0]}};
      end
      C_SZ_HALF: begin
        w_off   = {ex_mem_addr_i[1], 1'b0};
        sel_d   = ex_mem_addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{ex_reg2_i[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        sel_d   = 4'b1111;
        wdata_d = ex_reg2_i;
      end
    endcase
    addr_d = {ex_mem_addr_i[31:2], 2'b00};
  end

`ifdef MEM_ALIGN_EXC_EN
  assign w_misalign = w_is_mem &
                      (((w_size == C_SZ_HALF) & ex_mem_addr_i[0]) |
                       ((w_size == C_SZ_WORD) & (|ex_mem_addr_i[1:0])));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_issue = w_is_mem & ~w_misalign;

  // Big-endian lane extraction from the captured read word
  always_comb begin
    w_load_ext = rdata_q;
    case (w_size)
      C_SZ_BYTE: begin
        case (w_off)
          2'd0:    w_load_ext = {{24{w_signed & rdata_q[31]}}, rdata_q[31:24]};
          2'd1:    w_load_ext = {{24{w_signed & rdata_q[23]}}, rdata_q[23:16]};
          2'd2:    w_load_ext = {{24{w_signed & rdata_q[15]}}, rdata_q[15:8]};
          default: w_load_ext = {{24{w_signed & rdata_q[7]}},  rdata_q[7:0]};
        endcase
      end
      C_SZ_HALF: begin
        if (w_off[1]) w_load_ext = {{16{w_signed & rdata_q[15]}}, rdata_q[15:0]};
        else          w_load_ext = {{16{w_signed & rdata_q[31]}}, rdata_q[31:16]};
      end
      default: w_load_ext = rdata_q;
    endcase
  end

  // Reset makes the outputs behave as in IDLE, without stalling
  assign w_idle_view = rst_i | (state_q == S_IDLE);

  always_comb begin
    mem_wreg_o  = 1'b0;
    mem_wd_o    = ex_wd_i;
    mem_wdata_o = 32'h0000_0000;
    stallreq_o  = 1'b0;
    if (w_idle_view) begin
      if (!w_is_mem) begin
        mem_wreg_o  = ex_wreg_i;
        mem_wdata_o = ex_wdata_i;
      end else begin
        stallreq_o = w_issue & ~rst_i;
      end
    end else if (state_q == S_BUSY) begin
      stallreq_o = 1'b1;
    end else if (w_is_load) begin
      mem_wreg_o  = ex_wreg_i;
      mem_wdata_o = w_load_ext;
    end
  end

`ifdef MEM_ALIGN_EXC_EN
  assign mem_misalign_o = w_idle_view & w_misalign;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_sel_o   <= 4'b0000;
      dbus_addr_o  <= 32'h0000_0000;
      dbus_wdata_o <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_issue) begin
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= w_is_store;
            dbus_sel_o   <= sel_d;
            dbus_addr_o  <= addr_d;
            dbus_wdata_o <= wdata_d;
            state_q      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dbus_ack_i) begin
            rdata_q    <= dbus_rdata_i;
            dbus_req_o <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu : directed self-checking bench for mem_lsu.
`default_nettype none

module tb_mem_lsu;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wreg;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic        mem_wreg, stallreq;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  int          obs_stall;
  bit          obs_done, obs_seen_req, obs_unstable, obs_wreg_in_stall;
  logic [3:0]  obs_sel;
  logic [31:0] obs_addr, obs_bwdata, obs_mwdata;
  logic        obs_we, obs_mwreg, obs_mis;
  logic [4:0]  obs_mwd;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk_i(clk), .rst_i(rst),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
    .ex_aluop_i(ex_aluop), .ex_mem_addr_i(ex_mem_addr), .ex_reg2_i(ex_reg2),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_sel_o(dbus_sel),
    .dbus_addr_o(dbus_addr), .dbus_wdata_o(dbus_wdata),
    .dbus_ack_i(dbus_ack), .dbus_rdata_i(dbus_rdata),
    .mem_wreg_o(mem_wreg), .mem_wd_o(mem_wd), .mem_wdata_o(mem_wdata),
    .stallreq_o(stallreq)
`ifdef MEM_ALIGN_EXC_EN
    , .mem_misalign_o(misalign)
`endif
  );
`ifndef MEM_ALIGN_EXC_EN
  assign misalign = 1'b0;
`endif

  task automatic set_nop();
    ex_aluop = OP_NOP; ex_wreg = 1'b0; ex_wd = 5'd0;
    ex_wdata = 32'h0; ex_mem_addr = 32'h0; ex_reg2 = 32'h0;
  endtask

  // Drives one instruction and acts as bus slave; records what it sees.
  // Starts and ends just after a rising edge.
  task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [4:0] wd,
                           input int delay, input logic [31:0] rdata);
    int waitc = 0;
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
    ex_wreg = 1'b1; ex_wd = wd; ex_wdata = 32'hDEAD_0000;
    obs_stall = 0; obs_done = 0; obs_seen_req = 0; obs_unstable = 0;
    obs_wreg_in_stall = 0; obs_mis = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (stallreq) begin
        obs_stall++;
        if (mem_wreg) obs_wreg_in_stall = 1;
      end
      if (dbus_req) begin
        if (!obs_seen_req) begin
          obs_seen_req = 1; obs_sel = dbus_sel; obs_addr = dbus_addr;
          obs_we = dbus_we; obs_bwdata = dbus_wdata;
        end else if (dbus_sel !== obs_sel || dbus_addr !== obs_addr ||
                     dbus_we !== obs_we || dbus_wdata !== obs_bwdata) begin
          obs_unstable = 1;
        end
        if (waitc == delay) begin dbus_ack = 1'b1; dbus_rdata = rdata; end
        else begin dbus_ack = 1'b0; dbus_rdata = 32'h0; waitc++; end
      end else if (!stallreq) begin
        dbus_ack = 1'b0;
        obs_done = 1; obs_mwreg = mem_wreg; obs_mwd = mem_wd;
        obs_mwdata = mem_wdata; obs_mis = misalign;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_nop(); dbus_ack = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (dbus_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", dbus_req); end
    tests++; if (dbus_we !== 1'b0) begin fails++; $display("FAIL rst_we got %b want 0", dbus_we); end
    tests++; if (dbus_sel !== 4'b0000) begin fails++; $display("FAIL rst_sel got %b want 0000", dbus_sel); end
    tests++; if (dbus_addr !== 32'h0 || dbus_wdata !== 32'h0) begin fails++; $display("FAIL rst_bus addr %h wdata %h want 0", dbus_addr, dbus_wdata); end
    tests++; if (stallreq !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", stallreq); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_alu_pass();
    ex_aluop = OP_OR; ex_wreg = 1'b1; ex_wd = 5'd5; ex_wdata = 32'h1234;
    @(negedge clk);
    tests++; if (mem_wreg !== 1'b1 || mem_wd !== 5'd5) begin fails++; $display("FAIL alu_wreg got %b/%0d want 1/5", mem_wreg, mem_wd); end
    tests++; if (mem_wdata !== 32'h1234) begin fails++; $display("FAIL alu_wdata got %h want 00001234", mem_wdata); end
    tests++; if (stallreq !== 1'b0 || dbus_req !== 1'b0) begin fails++; $display("FAIL alu_stall stall %b req %b want 0/0", stallreq, dbus_req); end
    @(posedge clk); #1; set_nop();
  endtask

  task automatic test_lb();
    do_access(OP_LB, 32'h101, 32'h0, 5'd7, 0, 32'h00F0_0000);
    set_nop();
    tests++; if (!obs_done) begin fails++; $display("FAIL lb_timeout got no completion want completion"); end
    tests++; if (obs_sel !== 4'b0100 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin fails++; $display("FAIL lb_bus sel %b addr %h we %b want 0100/100/0", obs_sel, obs_addr, obs_we); end
    tests++; if (obs_mwdata !== 32'hFFFF_FFF0) begin fails++; $display("FAIL lb_data got %h want fffffff0", obs_mwdata); end
    tests++; if (obs_mwreg !== 1'b1 || obs_mwd !== 5'd7) begin fails++; $display("FAIL lb_wreg got %b/%0d want 1/7", obs_mwreg, obs_mwd); end
    tests++; if (obs_stall != 2) begin fails++; $display("FAIL lb_stall got %0d want 2", obs_stall); end
  endtask

  task automatic test_sh_delay();
    do_access(OP_SH, 32'h202, 32'hAAAA_BEEF, 5'd3, 3, 32'h0);
    set_nop();
    tests++; if (obs_we !== 1'b1 || obs_sel !== 4'b0011 || obs_addr !== 32'h200) begin fails++; $display("FAIL sh_bus we %b sel %b addr %h want 1/0011/200", obs_we, obs_sel, obs_addr); end
    tests++; if (obs_bwdata !== 32'hBEEF_BEEF) begin fails++; $display("FAIL sh_wdata got %h want beefbeef", obs_bwdata); end
    tests++; if (obs_unstable) begin fails++; $display("FAIL sh_hold got changed want stable"); end
    tests++; if (obs_wreg_in_stall || obs_mwreg !== 1'b0) begin fails++; $display("FAIL sh_wreg stall %b done %b want 0/0", obs_wreg_in_stall, obs_mwreg); end
    tests++; if (obs_stall != 5) begin fails++; $display("FAIL sh_stall got %0d want 5", obs_stall); end
  endtask

  task automatic test_stores();
    do_access(OP_SB, 32'h203, 32'h1122_3344, 5'd1, 0, 32'h0);
    tests++; if (obs_sel !== 4'b0001 || obs_bwdata !== 32'h4444_4444) begin fails++; $display("FAIL sb_bus sel %b wdata %h want 0001/44444444", obs_sel, obs_bwdata); end
    do_access(OP_SW, 32'h300, 32'hCAFE_F00D, 5'd1, 1, 32'h0);
    set_nop();
    tests++; if (obs_sel !== 4'b1111 || obs_bwdata !== 32'hCAFE_F00D || obs_addr !== 32'h300) begin fails++; $display("FAIL sw_bus sel %b wdata %h addr %h want 1111/cafef00d/300", obs_sel, obs_bwdata, obs_addr); end
  endtask

  task automatic test_half_ext();
    do_access(OP_LHU, 32'h10, 32'h0, 5'd4, 0, 32'h8001_1234);
    tests++; if (obs_sel !== 4'b1100 || obs_mwdata !== 32'h0000_8001) begin fails++; $display("FAIL lhu sel %b data %h want 1100/00008001", obs_sel, obs_mwdata); end
    do_access(OP_LH, 32'h10, 32'h0, 5'd4, 0, 32'h8001_1234);
    set_nop();
    tests++; if (obs_mwdata !== 32'hFFFF_8001) begin fails++; $display("FAIL lh data got %h want ffff8001", obs_mwdata); end
  endtask

  task automatic test_back_to_back();
    do_access(OP_LBU, 32'h7, 32'h0, 5'd2, 0, 32'h1234_56F7);
    tests++; if (obs_sel !== 4'b0001 || obs_mwdata !== 32'h0000_00F7 || obs_stall != 2) begin fails++; $display("FAIL b2b_lbu sel %b data %h stall %0d want 0001/000000f7/2", obs_sel, obs_mwdata, obs_stall); end
    do_access(OP_LB, 32'h6, 32'h0, 5'd2, 0, 32'h0000_8000);
    set_nop();
    tests++; if (obs_sel !== 4'b0010 || obs_mwdata !== 32'hFFFF_FF80 || obs_stall != 2) begin fails++; $display("FAIL b2b_lb sel %b data %h stall %0d want 0010/ffffff80/2", obs_sel, obs_mwdata, obs_stall); end
  endtask

  task automatic test_misalign();
    do_access(OP_LW, 32'h103, 32'h0, 5'd6, 0, 32'h0102_0304);
    set_nop();
`ifdef MEM_ALIGN_EXC_EN
    tests++; if (obs_seen_req || obs_stall != 0) begin fails++; $display("FAIL mis_noreq req %b stall %0d want 0/0", obs_seen_req, obs_stall); end
    tests++; if (obs_mis !== 1'b1 || obs_mwreg !== 1'b0) begin fails++; $display("FAIL mis_flag mis %b wreg %b want 1/0", obs_mis, obs_mwreg); end
`else
    tests++; if (obs_sel !== 4'b1111 || obs_addr !== 32'h100) begin fails++; $display("FAIL lw_align sel %b addr %h want 1111/100", obs_sel, obs_addr); end
    tests++; if (obs_mwdata !== 32'h0102_0304 || obs_mwreg !== 1'b1) begin fails++; $display("FAIL lw_data got %h/%b want 01020304/1", obs_mwdata, obs_mwreg); end
`endif
  endtask

  task automatic test_reset_busy();
    ex_aluop = OP_LW; ex_mem_addr = 32'h40; ex_wreg = 1'b1; ex_wd = 5'd9;
    @(negedge clk);
    @(negedge clk);
    tests++; if (dbus_req !== 1'b1) begin fails++; $display("FAIL rb_busy req got %b want 1", dbus_req); end
    rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h7777_7777; #1;
    tests++; if (stallreq !== 1'b0 || mem_wreg !== 1'b0) begin fails++; $display("FAIL rb_inrst stall %b wreg %b want 0/0", stallreq, mem_wreg); end
    @(negedge clk);
    rst = 1'b0; ex_aluop = OP_OR; ex_wreg = 1'b1; ex_wd = 5'd3; ex_wdata = 32'h55; #1;
    tests++; if (dbus_req !== 1'b0 || dbus_sel !== 4'b0000 || stallreq !== 1'b0) begin fails++; $display("FAIL rb_after req %b sel %b stall %b want 0/0000/0", dbus_req, dbus_sel, stallreq); end
    @(negedge clk);
    tests++; if (dbus_req !== 1'b0 || mem_wreg !== 1'b1 || mem_wdata !== 32'h55) begin fails++; $display("FAIL rb_lateack req %b wreg %b data %h want 0/1/00000055", dbus_req, mem_wreg, mem_wdata); end
    dbus_ack = 1'b0;
    @(posedge clk); #1; set_nop();
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_lb();
    test_sh_delay();
    test_stores();
    test_half_ext();
    test_back_to_back();
    test_misalign();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
